add23_arbiter: RTL

ADD23_ARBITER -- requirements
Module: add23_arbiter

---
 rtl/add23_pkg.sv | 20 ++
 rtl/add23_arbiter_rr_pick.sv | 40 ++++
 rtl/add23_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/add23_pkg.sv
// ---------------------------------------------------------------------------
// add23_pkg
// Shared constants and types for the add23_arbiter block.
//   ADD23_WIDTH_DEF : default operand MSB index (operands are WIDTH+1 bits)
//   ADD23_NREQ_DEF  : default number of requesters
//   TXN_CNT_W       : width of the completed-response counter
//   add23_state_e   : result-slot state, EMPTY=0 / FULL=1
// ---------------------------------------------------------------------------
package add23_pkg;

  localparam int ADD23_WIDTH_DEF = 22;
  localparam int ADD23_NREQ_DEF  = 4;
  localparam int TXN_CNT_W       = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } add23_state_e;

endpackage : add23_pkg

// File: rtl/add23_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. The search starts at ptr and walks
// upward with wrap; the first requester with valid high wins.
// Ports:
//   valid     [NREQ-1:0] : per-requester request valid
//   ptr       [IDW-1:0]  : index with highest priority this cycle
//   grant     [NREQ-1:0] : one-hot grant (all-zero when no valid)
//   grant_idx [IDW-1:0]  : binary index of the granted requester (0 if none)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      // Rotate the search window so ptr is examined first.
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule : rr_pick

// File: rtl/add23_arbiter.sv
// ---------------------------------------------------------------------------
// add23_arbiter
// NREQ requesters share one (WIDTH+1)-bit adder. A round-robin arbiter picks
// one operand pair per cycle; the sum is registered into a single result slot.
//
// Handshake: a transfer happens on a port in any cycle where valid and ready
// are both high. Requesters hold valid until they see ready; the result slot
// accepts a new request whenever it is empty or is being drained this cycle
// (slot_free), so back-to-back traffic sustains one result per cycle.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready is one-hot/zero)
//   req_a, req_b        : packed operands, requester i at [i*(WIDTH+1) +: WIDTH+1]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id, rsp_sum     : owner index and (A+B) mod 2^(WIDTH+1)
//   txn_cnt             : wrapping count of completed responses
//   dbg_state           : current result-slot state (EMPTY/FULL)
//   rsp_cout            : registered carry-out, only when ADD23_CARRY_OUT_EN
//                         is defined
// ---------------------------------------------------------------------------
module add23_arbiter
  import add23_pkg::*;
#(
  parameter int WIDTH = ADD23_WIDTH_DEF,
  parameter int NREQ  = ADD23_NREQ_DEF,
  localparam int W1   = WIDTH + 1,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*W1-1:0]   req_a,
  input  logic [NREQ*W1-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W1-1:0]        rsp_sum,
  output logic [TXN_CNT_W-1:0] txn_cnt,
  output add23_state_e         dbg_state
`ifdef ADD23_CARRY_OUT_EN
  ,
  output logic                 rsp_cout
`endif
);

  add23_state_e         state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [W1-1:0]        rsp_sum_q, rsp_sum_d;
  logic [TXN_CNT_W-1:0] txn_cnt_q, txn_cnt_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            slot_free;
  logic            req_xfer;
  logic            rsp_xfer;
  logic [W1-1:0]   op_a;
  logic [W1-1:0]   op_b;
  logic [W1-1:0]   sum;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Slot can take a new result if empty, or if the current one leaves now.
  assign slot_free = (state_q == ST_EMPTY) || rsp_ready;
  assign req_ready = (rst || !slot_free) ? '0 : grant;
  assign req_xfer  = |req_ready;
  assign rsp_xfer  = (state_q == ST_FULL) && rsp_ready;

  // Shared adder: operands muxed by the granted index, carry-in 0.
  assign op_a = req_a[int'(grant_idx)*W1 +: W1];
  assign op_b = req_b[int'(grant_idx)*W1 +: W1];

`ifdef ADD23_CARRY_OUT_EN
  logic rsp_cout_q, rsp_cout_d;
  logic sum_cout;
  assign {sum_cout, sum} = {1'b0, op_a} + {1'b0, op_b};
`else
  // Carry-out is simply truncated away.
  assign sum = op_a + op_b;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rsp_id_d  = rsp_id_q;
    rsp_sum_d = rsp_sum_q;
    txn_cnt_d = txn_cnt_q + TXN_CNT_W'(rsp_xfer);
`ifdef ADD23_CARRY_OUT_EN
    rsp_cout_d = rsp_cout_q;
`endif

    if (req_xfer) begin
      ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (req_xfer) state_d = ST_FULL;
      end
      ST_FULL: begin
        // A new request replaces the result in the same edge it drains.
        if (!req_xfer && rsp_xfer) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    if (req_xfer) begin
      rsp_id_d  = grant_idx;
      rsp_sum_d = sum;
`ifdef ADD23_CARRY_OUT_EN
      rsp_cout_d = sum_cout;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      ptr_q     <= '0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      txn_cnt_q <= '0;
`ifdef ADD23_CARRY_OUT_EN
      rsp_cout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rsp_id_q  <= rsp_id_d;
      rsp_sum_q <= rsp_sum_d;
      txn_cnt_q <= txn_cnt_d;
`ifdef ADD23_CARRY_OUT_EN
      rsp_cout_q <= rsp_cout_d;
`endif
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign txn_cnt   = txn_cnt_q;
  assign dbg_state = state_q;
`ifdef ADD23_CARRY_OUT_EN
  assign rsp_cout  = rsp_cout_q;
`endif

endmodule : add23_arbiter
